// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate front-end: FSM state
// encodings, car category encoding and default timing constants.
package parking_pkg;

  typedef enum logic [2:0] {
    E_IDLE   = 3'd0,
    E_DECIDE = 3'd1,
    E_OPEN   = 3'd2,
    E_DENY   = 3'd3,
    E_CLEAR  = 3'd4
  } entry_state_e;

  typedef enum logic [1:0] {
    X_IDLE  = 2'd0,
    X_CHECK = 2'd1,
    X_OPEN  = 2'd2,
    X_CLEAR = 2'd3
  } exit_state_e;

  localparam logic CAT_UNI     = 1'b1;
  localparam logic CAT_GENERAL = 1'b0;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_OPEN_TIMEOUT    = 1000;

endpackage

// File: rtl/sensor_debounce.sv
// Loop-sensor debouncer: the filtered level follows raw only after raw has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic filtered,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // raw is expected to be already synchronous to clock; any agreement with
  // the filtered level clears the run counter.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (raw != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = raw;
        rise_d = raw;
        fall_d = !raw;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filtered = filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate front-end: debounced entry/exit loops, one barrier FSM per
// lane, and single-event-per-cycle arbitration toward the occupancy counter.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT,
  parameter int COUNT_W         = 9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               entry_sensor,
  input  logic               entry_is_uni,
  input  logic               exit_sensor,
  input  logic               exit_is_uni,
  input  logic               uni_is_vacated_space,
  input  logic               is_vacated_space,
  input  logic [COUNT_W-1:0] uni_parked_car,
  input  logic [COUNT_W-1:0] parked_car,
  output logic               car_entered,
  output logic               is_uni_car_entered,
  output logic               car_exited,
  output logic               is_uni_car_exited,
  output logic               entry_barrier_open,
  output logic               exit_barrier_open,
  output logic               entry_denied,
  output logic               exit_error,
  output logic [2:0]         entry_state_dbg,
  output logic [1:0]         exit_state_dbg
);

  localparam int TW = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(OPEN_TIMEOUT - 1);

  logic en_filt, en_rise, en_fall;
  logic ex_filt, ex_rise, ex_fall;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_deb (
    .clock(clock), .reset_n(reset_n), .raw(entry_sensor),
    .filtered(en_filt), .rise(en_rise), .fall(en_fall)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
    .clock(clock), .reset_n(reset_n), .raw(exit_sensor),
    .filtered(ex_filt), .rise(ex_rise), .fall(ex_fall)
  );

  entry_state_e  e_state_q, e_state_d;
  exit_state_e   x_state_q, x_state_d;
  logic          e_cat_q, e_cat_d, x_cat_q, x_cat_d;
  logic [TW-1:0] e_tmr_q, e_tmr_d, x_tmr_q, x_tmr_d;
  logic          e_bar_q, e_bar_d, x_bar_q, x_bar_d;
  logic          e_deny_q, e_deny_d, x_err_q, x_err_d;
  logic          pe_q, pe_d, pec_q, pec_d, px_q, px_d, pxc_q, pxc_d;
  logic          ent_q, ent_d, ent_uni_q, ent_uni_d;
  logic          ext_q, ext_d, ext_uni_q, ext_uni_d;
  logic          e_commit, x_commit;
  logic          e_space_ok;
  logic [COUNT_W-1:0] x_count;

  assign e_space_ok = (e_cat_q == CAT_GENERAL) ? is_vacated_space : uni_is_vacated_space;
  assign x_count    = (x_cat_q == CAT_UNI) ? uni_parked_car : parked_car;

  // Entry lane. Outputs are computed for the state being entered, so the
  // barrier and denied flops line up with the registered state.
  always_comb begin
    e_state_d = e_state_q;
    e_cat_d   = e_cat_q;
    e_tmr_d   = '0;
    e_bar_d   = 1'b0;
    e_deny_d  = 1'b0;
    e_commit  = 1'b0;
    case (e_state_q)
      E_IDLE: if (en_rise) begin
        e_state_d = E_DECIDE;
        e_cat_d   = entry_is_uni;
      end
      E_DECIDE: if (e_space_ok) begin
        e_state_d = E_OPEN;
        e_bar_d   = 1'b1;
      end else begin
        e_state_d = E_DENY;
        e_deny_d  = 1'b1;
      end
      E_OPEN: if (!en_filt) begin
        e_state_d = E_IDLE;
        e_commit  = 1'b1;
      end else if (e_tmr_q == TMO_LAST) begin
        e_state_d = E_CLEAR;
      end else begin
        e_tmr_d = e_tmr_q + TW'(1);
        e_bar_d = 1'b1;
      end
      E_DENY: if (!en_filt) e_state_d = E_IDLE;
              else          e_deny_d  = 1'b1;
      E_CLEAR: if (!en_filt) e_state_d = E_IDLE;
      default: e_state_d = E_IDLE;
    endcase
  end

  always_comb begin
    x_state_d = x_state_q;
    x_cat_d   = x_cat_q;
    x_tmr_d   = '0;
    x_bar_d   = 1'b0;
    x_err_d   = 1'b0;
    x_commit  = 1'b0;
    case (x_state_q)
      X_IDLE: if (ex_rise) begin
        x_state_d = X_CHECK;
        x_cat_d   = exit_is_uni;
      end
      X_CHECK: if (x_count == '0) begin
        x_state_d = X_CLEAR;
        x_err_d   = 1'b1;
      end else begin
        x_state_d = X_OPEN;
        x_bar_d   = 1'b1;
      end
      X_OPEN: if (!ex_filt) begin
        x_state_d = X_IDLE;
        x_commit  = 1'b1;
      end else if (x_tmr_q == TMO_LAST) begin
        x_state_d = X_CLEAR;
      end else begin
        x_tmr_d = x_tmr_q + TW'(1);
        x_bar_d = 1'b1;
      end
      X_CLEAR: if (!ex_filt) x_state_d = X_IDLE;
      default: x_state_d = X_IDLE;
    endcase
  end

  // One event per cycle: a held entry goes first, then exits, then a fresh
  // entry. Each lane holds at most one deferred event.
  always_comb begin
    ent_d     = 1'b0;
    ent_uni_d = 1'b0;
    ext_d     = 1'b0;
    ext_uni_d = 1'b0;
    pe_d      = pe_q;
    pec_d     = pec_q;
    px_d      = px_q;
    pxc_d     = pxc_q;
    if (pe_q) begin
      ent_d     = 1'b1;
      ent_uni_d = pec_q;
      pe_d      = 1'b0;
      if (x_commit) begin
        px_d  = 1'b1;
        pxc_d = x_cat_q;
      end
    end else if (px_q || x_commit) begin
      ext_d     = 1'b1;
      ext_uni_d = px_q ? pxc_q : x_cat_q;
      px_d      = 1'b0;
      if (e_commit) begin
        pe_d  = 1'b1;
        pec_d = e_cat_q;
      end
    end else if (e_commit) begin
      ent_d     = 1'b1;
      ent_uni_d = e_cat_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e_state_q <= E_IDLE;
      x_state_q <= X_IDLE;
      e_cat_q   <= 1'b0;
      x_cat_q   <= 1'b0;
      e_tmr_q   <= '0;
      x_tmr_q   <= '0;
      e_bar_q   <= 1'b0;
      x_bar_q   <= 1'b0;
      e_deny_q  <= 1'b0;
      x_err_q   <= 1'b0;
      pe_q      <= 1'b0;
      pec_q     <= 1'b0;
      px_q      <= 1'b0;
      pxc_q     <= 1'b0;
      ent_q     <= 1'b0;
      ent_uni_q <= 1'b0;
      ext_q     <= 1'b0;
      ext_uni_q <= 1'b0;
    end else begin
      e_state_q <= e_state_d;
      x_state_q <= x_state_d;
      e_cat_q   <= e_cat_d;
      x_cat_q   <= x_cat_d;
      e_tmr_q   <= e_tmr_d;
      x_tmr_q   <= x_tmr_d;
      e_bar_q   <= e_bar_d;
      x_bar_q   <= x_bar_d;
      e_deny_q  <= e_deny_d;
      x_err_q   <= x_err_d;
      pe_q      <= pe_d;
      pec_q     <= pec_d;
      px_q      <= px_d;
      pxc_q     <= pxc_d;
      ent_q     <= ent_d;
      ent_uni_q <= ent_uni_d;
      ext_q     <= ext_d;
      ext_uni_q <= ext_uni_d;
    end
  end

  assign car_entered        = ent_q;
  assign is_uni_car_entered = ent_uni_q;
  assign car_exited         = ext_q;
  assign is_uni_car_exited  = ext_uni_q;
  assign entry_barrier_open = e_bar_q;
  assign exit_barrier_open  = x_bar_q;
  assign entry_denied       = e_deny_q;
  assign exit_error         = x_err_q;
  assign entry_state_dbg    = e_state_q;
  assign exit_state_dbg     = x_state_q;

endmodule
